afifo_rd_arbiter: RTL and testbench
===================================

Name: afifo_rd_arbiter

Overview:
- Read-domain scheduler that drains NCH asynchronous FIFOs into one shared downstream valid/ready stream.
- Sits on the read clock, directly behind each FIFO's first-word-fall-through read port (rempty, rdata, rinc).
- Grants channels round-robin, holding each grant for a bounded burst, and registers the selected word plus its channel index onto the output.

Parameters:
- NCH, 4, number of FIFO read ports; 2..8.
- DATA_WD, 8, FIFO word width.
- BURST_MAX, 4, maximum words popped per grant; 1..15.
- CH_WD, $clog2(NCH), channel index width; derived, not overridden.

Ports:
- clk  in  1  read-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_en  in  NCH  per-channel enable; disabled channels are never granted.
- rempty  in  NCH  per-FIFO empty flag, registered in the read domain.
- rdata  in  NCH*DATA_WD  per-FIFO head word; channel i occupies bits [i*DATA_WD +: DATA_WD].
- rinc  out  NCH  one-hot pop strobe; at most one bit high per cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WD  output word.
- m_chan  out  CH_WD  source channel of m_data.
- busy  out  1  high in ST_BURST.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_chan=0, busy=0, state=ST_IDLE, rr_ptr=0, burst_cnt=0. rinc is forced to 0 while rst_n is low.
- Output slot:
  - slot_free = !m_valid || m_ready.
  - A pop loads m_data/m_chan and sets m_valid on the same edge as rinc.
  - m_valid clears on m_valid && m_ready with no pop.
- Eligible channel: cfg_en[i] && !rempty[i].
- Pick: the first eligible channel at or after rr_ptr, modulo NCH.
- ST_IDLE:
  - If any channel is eligible and slot_free: pop the picked channel (rinc[pick]=1), gnt<=pick, burst_cnt<=1, go to ST_BURST.
  - If BURST_MAX==1: stay in ST_IDLE and set rr_ptr<=pick+1 instead.
- ST_BURST, evaluated each cycle in priority order:
  1. !cfg_en[gnt] or rempty[gnt]: no pop, rr_ptr<=gnt+1, go to ST_IDLE. This costs one bubble cycle.
  2. !slot_free: hold; no pop, counter unchanged.
  3. Otherwise: pop gnt, burst_cnt++. If burst_cnt+1==BURST_MAX, rr_ptr<=gnt+1 and go to ST_IDLE.
- Latency:
  - rempty falling in ST_IDLE with a free slot gives rinc that cycle and m_valid the next cycle.
  - Throughput is 1 word/cycle within a burst when m_ready is held high.
- Backpressure: when m_ready=0 with m_valid=1, no rinc; m_data/m_chan stay stable.
- Wrap-around: rr_ptr wraps NCH-1 -> 0. pick+1 wraps identically.
- A cfg_en drop during a burst ends the burst at the next evaluation. A word already in the output slot is still delivered.
- Reset mid-burst: state and output are cleared immediately. The in-flight m_data word is lost, but no FIFO word is lost because rinc goes low asynchronously.
- Pointer arithmetic is modulo NCH, using compare-and-wrap rather than power-of-two masking.

Optional Feature:
- Macro: AFIFO_ARB_STRICT_PRIO_EN.
- Defined: pick is the lowest-index eligible channel. rr_ptr is held at 0 and is not updated. The BURST_MAX limit still ends bursts so that a higher-priority channel can preempt at burst boundaries.
- Undefined: round-robin as specified above.

Decomposition:
- Package afifo_arb_pkg:
  - state enum {ST_IDLE, ST_BURST};
  - function next_ch(ch, nch) for modulo increment;
  - localparam for the burst counter width.
- One sub-module, afifo_rr_pick:
  - combinational priority-rotate picker;
  - inputs: eligible vector, rr_ptr;
  - outputs: pick index and any_valid;
  - contains the strict-priority ifdef.

Test Plan:
- Reset/idle: rst_n=0, all rempty=1 -> rinc=0, m_valid=0, m_data=0. After release, ch2 gets rempty=0 holding word 0xA5 -> rinc=4'b0100 that cycle; next cycle m_valid=1, m_data=0xA5, m_chan=2.
- Burst limit: ch0 holds 10 words, BURST_MAX=4, m_ready=1 -> exactly 4 consecutive pops from ch0; when ch1 is also non-empty, the 5th pop is from ch1.
- Round-robin wrap: all 4 channels hold 1 word each, rr_ptr=3 -> output order 3,0,1,2.
- Backpressure: m_ready=0 for 5 cycles mid-burst -> rinc=0 throughout and m_data stable; burst_cnt resumes from its held value after m_ready=1.
- Early end: ch1 empties after 2 of 4 words, or cfg_en[1] is dropped -> burst ends with no extra pop, one bubble cycle, then the next eligible channel is granted.
- Strict priority (AFIFO_ARB_STRICT_PRIO_EN defined): ch3 is streaming and ch0 becomes non-empty -> at the next burst boundary ch0 is granted ahead of ch1/ch2.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// afifo_arb_pkg: shared types and helpers for the async-FIFO read arbiter.
// Holds the FSM state encoding, the burst counter width and the
// modulo channel increment used by both the picker and the FSM.
package afifo_arb_pkg;

  // Wide enough for BURST_MAX up to 15.
  localparam int BURST_CNT_WD = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Channel increment with compare-and-wrap, so non-power-of-two NCH works.
  function automatic int next_ch(input int ch, input int nch);
    if (ch >= nch - 1) begin
      return 0;
    end
    return ch + 1;
  endfunction

endpackage

// File: rtl/afifo_rd_arbiter_pick.sv
// afifo_rr_pick: combinational channel picker for the read arbiter.
// Round-robin: first eligible channel at or after i_rr_ptr, modulo NCH.
// With AFIFO_ARB_STRICT_PRIO_EN defined the rotation is ignored and the
// lowest-index eligible channel wins.
module afifo_rr_pick
  import afifo_arb_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CH_WD = $clog2(NCH)
) (
  input  logic [NCH-1:0]   i_elig,
  input  logic [CH_WD-1:0] i_rr_ptr,
  output logic [CH_WD-1:0] o_pick,
  output logic             o_any
);

  logic [CH_WD-1:0] w_pick;
  logic             w_found;

`ifdef AFIFO_ARB_STRICT_PRIO_EN
  // The rotation pointer has no meaning under fixed priority.
  logic w_rr_ptr_unused;
  assign w_rr_ptr_unused = ^i_rr_ptr;

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && i_elig[i]) begin
        w_pick  = CH_WD'(i);
        w_found = 1'b1;
      end
    end
  end
`else
  logic [CH_WD-1:0] w_idx;

  // Rotating scan starting at the round-robin pointer.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = i_rr_ptr;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && i_elig[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
      w_idx = CH_WD'(next_ch(int'(w_idx), NCH));
    end
  end
`endif

  assign o_pick = w_pick;
  assign o_any  = w_found;

endmodule

// File: rtl/afifo_rd_arbiter.sv
// afifo_rd_arbiter: drains NCH first-word-fall-through async FIFO read
// ports into one valid/ready stream, granting channels round-robin with a
// bounded burst per grant. The popped word and its channel are registered
// onto the output on the same edge as the pop strobe.
// Build option: AFIFO_ARB_STRICT_PRIO_EN selects fixed lowest-index priority
// (rr_ptr held at 0); bursts are still capped so higher priority can preempt.
//
// state    | meaning
// ST_IDLE  | no grant held; pop the picked channel when the output slot is free
// ST_BURST | grant held on r_gnt; pop it until empty, disabled or BURST_MAX
module afifo_rd_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DATA_WD   = 8,
  parameter int BURST_MAX = 4,
  localparam int CH_WD    = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         cfg_en,
  input  logic [NCH-1:0]         rempty,
  input  logic [NCH*DATA_WD-1:0] rdata,
  output logic [NCH-1:0]         rinc,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WD-1:0]     m_data,
  output logic [CH_WD-1:0]       m_chan,
  output logic                   busy
);

  state_t                  r_state;
  logic [CH_WD-1:0]        r_rr_ptr;
  logic [CH_WD-1:0]        r_gnt;
  logic [BURST_CNT_WD-1:0] r_burst_cnt;
  logic                    r_m_valid;
  logic [DATA_WD-1:0]      r_m_data;
  logic [CH_WD-1:0]        r_m_chan;

  logic [NCH-1:0]     w_elig;
  logic [CH_WD-1:0]   w_pick;
  logic               w_any;
  logic               w_slot_free;
  logic               w_stop;
  logic               w_pop;
  logic [CH_WD-1:0]   w_pop_ch;
  logic [DATA_WD-1:0] w_pop_data;
  logic               w_last;
  logic [NCH-1:0]     w_rinc;

  assign w_elig      = cfg_en & ~rempty;
  assign w_slot_free = !r_m_valid || m_ready;
  // This pop is the last one allowed in the current grant.
  assign w_last      = (r_burst_cnt == BURST_CNT_WD'(BURST_MAX - 1));

  afifo_rr_pick #(
    .NCH (NCH)
  ) u_pick (
    .i_elig   (w_elig),
    .i_rr_ptr (r_rr_ptr),
    .o_pick   (w_pick),
    .o_any    (w_any)
  );

  // Pop decision: which channel (if any) is popped this cycle.
  always_comb begin
    w_pop    = 1'b0;
    w_stop   = 1'b0;
    w_pop_ch = r_gnt;
    case (r_state)
      ST_IDLE: begin
        w_pop_ch = w_pick;
        w_pop    = w_any && w_slot_free;
      end
      ST_BURST: begin
        w_stop = !cfg_en[r_gnt] || rempty[r_gnt];
        w_pop  = !w_stop && w_slot_free;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  assign w_pop_data = rdata[int'(w_pop_ch)*DATA_WD +: DATA_WD];

  // One-hot pop strobe; gated by rst_n so no FIFO word is consumed in reset.
  always_comb begin
    w_rinc = '0;
    if (rst_n && w_pop) begin
      w_rinc[w_pop_ch] = 1'b1;
    end
  end

  assign rinc = w_rinc;

  // Grant FSM, burst counter, rr pointer and the registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_burst_cnt <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_chan    <= '0;
    end else begin
      if (w_pop) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_pop_data;
        r_m_chan  <= w_pop_ch;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_gnt <= w_pick;
            if (BURST_MAX == 1) begin
`ifndef AFIFO_ARB_STRICT_PRIO_EN
              r_rr_ptr <= CH_WD'(next_ch(int'(w_pick), NCH));
`endif
            end else begin
              r_burst_cnt <= BURST_CNT_WD'(1);
              r_state     <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (w_stop) begin
            // Granted FIFO ran dry or was disabled: release, one bubble cycle.
`ifndef AFIFO_ARB_STRICT_PRIO_EN
            r_rr_ptr <= CH_WD'(next_ch(int'(r_gnt), NCH));
`endif
            r_state <= ST_IDLE;
          end else if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_last) begin
`ifndef AFIFO_ARB_STRICT_PRIO_EN
              r_rr_ptr <= CH_WD'(next_ch(int'(r_gnt), NCH));
`endif
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_chan  = r_m_chan;
  assign busy    = (r_state == ST_BURST);

endmodule

// File: tb/tb_afifo_rd_arbiter.sv
// Bench for afifo_rd_arbiter: FWFT FIFO models feed the DUT, expected
// output words are queued in arbitration order and matched on each
// m_valid && m_ready transfer.
module tb_afifo_rd_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int BM  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  cfg_en;
  logic [NCH-1:0]  rempty;
  logic [NCH*DW-1:0] rdata;
  logic [NCH-1:0]  rinc;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_chan;
  logic            busy;

  logic [DW-1:0]   fq [NCH][$];
  logic [9:0]      exp_q [$];
  int              pop_cyc [$];
  int              cyc = 0;
  logic [NCH-1:0]  seen_rinc;
  int              n_chk = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  afifo_rd_arbiter #(
    .NCH       (NCH),
    .DATA_WD   (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_chan  (m_chan),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      rempty[i] = (fq[i].size() == 0);
      rdata[i*DW +: DW] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endtask

  task automatic expect_w(input logic [1:0] ch, input logic [7:0] d);
    exp_q.push_back({ch, d});
  endtask

  // One clock: sample pops/output mid-cycle, let the edge happen, pop models.
  task automatic step();
    logic [DW-1:0] dummy;
    refresh();
    #1;
    seen_rinc = rinc;
    check("rinc_onehot", 32'($onehot0(rinc)), 32'd1);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0)
        check("sb_extra_word", 32'(exp_q.size()), 32'd1);
      else
        check("sb_word", 32'({m_chan, m_data}), 32'(exp_q.pop_front()));
    end
    if (seen_rinc != '0) pop_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (seen_rinc[i] && fq[i].size() > 0) dummy = fq[i].pop_front();
    end
    refresh();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    cfg_en  = '1;
    m_ready = 1'b1;
    refresh();
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_m_chan",  32'(m_chan),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    fq[0].push_back(8'h11);
    refresh();
    #1;
    check("rst_rinc_low", 32'(rinc), 32'd0);
    fq[0].delete();
    refresh();
    @(negedge clk);
    rst_n = 1'b1;

    // First word: pop same cycle, output next cycle.
    fq[2].push_back(8'hA5);
    expect_w(2'd2, 8'hA5);
    step();
    check("lat_rinc",    32'(seen_rinc), 32'(4'b0100));
    check("lat_m_valid", 32'(m_valid),   32'd1);
    check("lat_m_data",  32'(m_data),    32'h0A5);
    check("lat_m_chan",  32'(m_chan),    32'd2);
    check("lat_busy",    32'(busy),      32'd1);
    drain("drain_first", 20);

`ifdef AFIFO_ARB_STRICT_PRIO_EN
    // ch3 streams; lower channels arrive mid-burst and win at the boundary.
    for (int k = 0; k < 8; k++) fq[3].push_back(8'(8'h90 + k));
    for (int k = 0; k < 4; k++) expect_w(2'd3, 8'(8'h90 + k));
    expect_w(2'd0, 8'hA0);
    expect_w(2'd1, 8'hB0);
    expect_w(2'd2, 8'hC0);
    for (int k = 4; k < 8; k++) expect_w(2'd3, 8'(8'h90 + k));
    step();
    step();
    fq[0].push_back(8'hA0);
    fq[1].push_back(8'hB0);
    fq[2].push_back(8'hC0);
    drain("drain_strict", 60);
`else
    // rr_ptr is now 3 (ch2 burst ended on empty): order wraps 3,0,1,2.
    for (int c = 0; c < NCH; c++) fq[c].push_back(8'(8'hC0 + c));
    expect_w(2'd3, 8'hC3);
    expect_w(2'd0, 8'hC0);
    expect_w(2'd1, 8'hC1);
    expect_w(2'd2, 8'hC2);
    drain("drain_wrap", 40);

    // Burst limit: 4 back-to-back from ch0, then ch1 immediately.
    pop_cyc.delete();
    for (int k = 0; k < 10; k++) fq[0].push_back(8'(k));
    for (int k = 0; k < 2; k++) fq[1].push_back(8'(8'h40 + k));
    for (int k = 0; k < 4; k++) expect_w(2'd0, 8'(k));
    for (int k = 0; k < 2; k++) expect_w(2'd1, 8'(8'h40 + k));
    for (int k = 4; k < 10; k++) expect_w(2'd0, 8'(k));
    drain("drain_burst", 60);
    check("burst_pop_count", 32'(pop_cyc.size()), 32'd12);
    if (pop_cyc.size() >= 8) begin
      check("burst_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
      check("burst_next_grant",   32'(pop_cyc[4] - pop_cyc[3]), 32'd1);
      check("empty_end_bubble",   32'(pop_cyc[6] - pop_cyc[5]), 32'd2);
    end

    // Backpressure mid-burst; counter must resume from its held value.
    for (int k = 0; k < 6; k++) fq[1].push_back(8'(8'h50 + k));
    fq[2].push_back(8'h60);
    for (int k = 0; k < 4; k++) expect_w(2'd1, 8'(8'h50 + k));
    expect_w(2'd2, 8'h60);
    expect_w(2'd1, 8'h54);
    expect_w(2'd1, 8'h55);
    step();
    step();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_rinc",    32'(seen_rinc), 32'd0);
      check("bp_m_data",  32'(m_data),    32'h51);
      check("bp_m_valid", 32'(m_valid),   32'd1);
    end
    m_ready = 1'b1;
    drain("drain_bp", 40);

    // cfg_en drop mid-burst: no extra pop, one bubble, next channel granted.
    for (int k = 0; k < 6; k++) fq[3].push_back(8'(8'h70 + k));
    fq[0].push_back(8'h80);
    expect_w(2'd3, 8'h70);
    expect_w(2'd3, 8'h71);
    expect_w(2'd0, 8'h80);
    for (int k = 2; k < 6; k++) expect_w(2'd3, 8'(8'h70 + k));
    step();
    check("cfg_first_pop", 32'(seen_rinc), 32'(4'b1000));
    step();
    cfg_en = 4'b0111;
    step();
    check("cfgdrop_bubble", 32'(seen_rinc), 32'd0);
    step();
    check("cfgdrop_next", 32'(seen_rinc), 32'(4'b0001));
    cfg_en = 4'b1111;
    drain("drain_cfg", 40);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
